// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory backing store: access size codes,
// responder FSM states and the out-of-range read pattern.
package mem_pkg;

  localparam logic [2:0] SZ_B   = 3'b000;
  localparam logic [2:0] SZ_H   = 3'b001;
  localparam logic [2:0] SZ_W   = 3'b010;
  localparam logic [2:0] SZ_BU  = 3'b100;
  localparam logic [2:0] SZ_HU  = 3'b101;
  localparam logic [2:0] SZ_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic [31:0] BOUNDS_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_lane_fmt.sv
// Load formatter: turns four little-endian raw bytes into the sign- or
// zero-extended result selected by the size code.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_B:    data = {{24{raw[7]}}, raw[7:0]};
      SZ_BU:   data = {24'h0, raw[7:0]};
      SZ_H:    data = {{16{raw[15]}}, raw[15:0]};
      SZ_HU:   data = {16'h0, raw[15:0]};
      SZ_NOP:  data = 32'h0;
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_backing_store.sv
// Fixed-latency main-memory responder (byte array, little-endian, wrapping).
// Optional macro MEM_BOUNDS_CHECK_EN rejects addresses above the array size.
//
// Handshake: mem_read/mem_write are levels held by the initiator until
// mem_ready; mem_ready is a single-cycle pulse in RESP, the initiator drops
// the request in that cycle, and any request seen in IDLE is a new one.
module mem_backing_store
  import mem_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 17,
  parameter int    LATENCY    = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            SizeCtr,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  mem_ready
);

  localparam int          MEM_BYTES = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  logic [7:0] mem [MEM_BYTES];

  mem_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic                  lat_rd, lat_wr, lat_oob;
  logic [2:0]            lat_size;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;

  logic addr_oob;
`ifdef MEM_BOUNDS_CHECK_EN
  assign addr_oob = |address[31:ADDR_WIDTH];
`else
  logic unused_upper_addr;
  assign addr_oob          = 1'b0;
  assign unused_upper_addr = ^address[31:ADDR_WIDTH];
`endif

  wire req = mem_read | mem_write;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd1) state_nxt = RESP;
        cnt_nxt = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is the acceptance edge, so the live
  // inputs stand in for the not-yet-latched copy.
  wire                  from_idle = (state == IDLE);
  wire                  op_rd     = from_idle ? mem_read   : lat_rd;
  wire                  op_wr     = from_idle ? mem_write  : lat_wr;
  wire                  op_oob    = from_idle ? addr_oob   : lat_oob;
  wire [2:0]            op_size   = from_idle ? SizeCtr    : lat_size;
  wire [ADDR_WIDTH-1:0] op_addr   = from_idle ? address[ADDR_WIDTH-1:0] : lat_addr;
  wire [31:0]           op_wdata  = from_idle ? write_data : lat_wdata;

  wire commit = rst_n && (state_nxt == RESP) && (state != RESP);

  logic [ADDR_WIDTH-1:0] baddr [4];
  logic [31:0]           raw;
  logic [3:0]            byte_en;
  logic [31:0]           fmt_data;

  always_comb begin
    raw = 32'h0;
    for (int i = 0; i < 4; i++) begin
      baddr[i]        = op_addr + ADDR_WIDTH'(i);
      raw[8*i +: 8]   = mem[baddr[i]];
    end
  end

  always_comb begin
    case (op_size)
      SZ_B, SZ_BU: byte_en = 4'b0001;
      SZ_H, SZ_HU: byte_en = 4'b0011;
      SZ_NOP:      byte_en = 4'b0000;
      default:     byte_en = 4'b1111;
    endcase
  end

  mem_lane_fmt u_fmt (
    .raw  (raw),
    .size (op_size),
    .data (fmt_data)
  );

  // Array has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (commit && op_wr && !op_oob) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[baddr[i]] <= op_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      read_data <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_oob   <= 1'b0;
      lat_size  <= SZ_W;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (from_idle && req) begin
        lat_rd    <= mem_read;
        lat_wr    <= mem_write;
        lat_oob   <= addr_oob;
        lat_size  <= SizeCtr;
        lat_addr  <= address[ADDR_WIDTH-1:0];
        lat_wdata <= write_data;
      end
      // A simultaneous write wins; read_data keeps its old value.
      if (commit && op_rd && !op_wr) begin
        read_data <= op_oob ? BOUNDS_ERR_DATA : fmt_data;
      end
    end
  end

  assign mem_ready = (state == RESP);

endmodule

// File: tb/tb_mem_backing_store.sv
// Self-checking bench for mem_backing_store: directed vector table, held-request,
// mid-transaction reset and bounds sequences, then random traffic vs a byte model.
module tb_mem_backing_store;

  localparam int LAT       = 4;
  localparam int AW        = 17;
  localparam int MEM_BYTES = 1 << AW;
  localparam int BUDGET    = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  size_ctr;
  logic [31:0] address, write_data, read_data;
  logic        mem_ready;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] last_rd;
  logic [7:0]  ref_mem [int];
  logic [31:0] exp_q [$];

  mem_backing_store #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .SizeCtr    (size_ctr),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_ready  (mem_ready)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b111:         return 0;
      default:        return 4;
    endcase
  endfunction

  function automatic bit ref_oob(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return a >= MEM_BYTES;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] sz);
    longint v = 0;
    int n = size_bytes(sz);
    if (ref_oob(a)) return 32'hDEADBEEF;
    for (int i = 0; i < n; i++) begin
      longint key = (longint'(a) + i) % MEM_BYTES;
      v = v + longint'(ref_mem[int'(key)]) * (longint'(1) << (8 * i));
    end
    if ((sz == 3'b000 || sz == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int n = size_bytes(sz);
    if (ref_oob(a)) return;
    for (int i = 0; i < n; i++) begin
      longint key = (longint'(a) + i) % MEM_BYTES;
      ref_mem[int'(key)] = 8'((d >> (8 * i)) & 32'hFF);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_txn(input string name, input logic rd, input logic wr,
                        input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got);
    int n;
    @(negedge clk);
    mem_read = rd; mem_write = wr; size_ctr = sz; address = a; write_data = wd;
    @(posedge clk);
    n = 1;
    #1;
    while (!mem_ready && n < BUDGET) begin
      @(posedge clk);
      n++;
      #1;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    got = read_data;
    chk({name, "_ready"}, 32'(mem_ready), 32'd1);
    chk({name, "_lat"}, 32'(n), 32'(LAT));
    @(posedge clk);
    #1;
    chk({name, "_pulse"}, 32'(mem_ready), 32'd0);
  endtask

  // Applies the model and scoreboards the response.
  task automatic model_txn(input string name, input logic rd, input logic wr,
                           input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] got;
    if (rd && !wr) last_rd = ref_read(a, sz);
    if (wr) ref_write(a, sz, wd);
    exp_q.push_back(last_rd);
    do_txn(name, rd, wr, sz, a, wd, got);
    chk({name, "_data"}, got, exp_q.pop_front());
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input string nm, input logic rd, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] e);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.sz = sz; v.addr = a; v.wdata = wd; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] got;
    int n;

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    size_ctr = 3'b010; address = '0; write_data = '0;
    last_rd = '0;
    #2;
    chk("reset_ready", 32'(mem_ready), 32'd0);
    chk("reset_data", read_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // exp is the expected read_data after the transaction (writes keep the old value).
    add_vec("w_100",     0, 1, 3'b010, 32'h100,   32'h12345678, 32'h0);
    add_vec("rw_100",    1, 0, 3'b010, 32'h100,   32'h0,        32'h12345678);
    add_vec("rb_103",    1, 0, 3'b000, 32'h103,   32'h0,        32'h00000012);
    add_vec("wb_100",    0, 1, 3'b000, 32'h100,   32'h00000080, 32'h00000012);
    add_vec("rbu_100",   1, 0, 3'b100, 32'h100,   32'h0,        32'h00000080);
    add_vec("rb_100",    1, 0, 3'b000, 32'h100,   32'h0,        32'hFFFFFF80);
    add_vec("wh_100",    0, 1, 3'b001, 32'h100,   32'h00008001, 32'hFFFFFF80);
    add_vec("rh_100",    1, 0, 3'b001, 32'h100,   32'h0,        32'hFFFF8001);
    add_vec("rhu_100",   1, 0, 3'b101, 32'h100,   32'h0,        32'h00008001);
    add_vec("rw_mix",    1, 0, 3'b010, 32'h100,   32'h0,        32'h12348001);
    add_vec("w_top",     0, 1, 3'b010, 32'h1FFFE, 32'hAABBCCDD, 32'h12348001);
    add_vec("rw_top",    1, 0, 3'b010, 32'h1FFFE, 32'h0,        32'hAABBCCDD);
    add_vec("rbu_0",     1, 0, 3'b100, 32'h0,     32'h0,        32'h000000BB);
    add_vec("rbu_1",     1, 0, 3'b100, 32'h1,     32'h0,        32'h000000AA);
    add_vec("rh_wrap",   1, 0, 3'b001, 32'h1FFFF, 32'h0,        32'hFFFFBBCC);
    add_vec("nop_rd",    1, 0, 3'b111, 32'h100,   32'h0,        32'h00000000);
    add_vec("nop_wr",    0, 1, 3'b111, 32'h100,   32'hFFFFFFFF, 32'h00000000);
    add_vec("rw_nop",    1, 0, 3'b010, 32'h100,   32'h0,        32'h12348001);
    add_vec("both_100",  1, 1, 3'b010, 32'h100,   32'hCAFEF00D, 32'h12348001);
    add_vec("rw_both",   1, 0, 3'b010, 32'h100,   32'h0,        32'hCAFEF00D);
    add_vec("r011_100",  1, 0, 3'b011, 32'h100,   32'h0,        32'hCAFEF00D);

    foreach (vecs[i]) begin
      do_txn(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wdata, got);
      chk({vecs[i].name, "_data"}, got, vecs[i].exp);
      if (vecs[i].wr) ref_write(vecs[i].addr, vecs[i].sz, vecs[i].wdata);
      else last_rd = vecs[i].exp;
    end

    // Request held through RESP and one IDLE cycle: second acceptance, no double pulse.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; size_ctr = 3'b010; address = 32'h100;
    @(posedge clk);
    n = 1;
    #1;
    while (!mem_ready && n < BUDGET) begin @(posedge clk); n++; #1; end
    chk("hold_lat1", 32'(n), 32'(LAT));
    chk("hold_data1", read_data, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("hold_idle", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    n = 1;
    chk("hold_busy", 32'(mem_ready), 32'd0);
    while (!mem_ready && n < BUDGET) begin @(posedge clk); n++; #1; end
    chk("hold_lat2", 32'(n), 32'(LAT));
    chk("hold_ready2", 32'(mem_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold_no_extra", 32'(mem_ready), 32'd0);
    end

    // Reset two cycles into a write: no commit, outputs cleared at once.
    model_txn("w_200", 0, 1, 3'b010, 32'h200, 32'h0BADF00D);
    model_txn("r_200", 1, 0, 3'b010, 32'h200, 32'h0);
    @(negedge clk);
    mem_write = 1'b1; size_ctr = 3'b010; address = 32'h200; write_data = 32'hFFFFFFFF;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(mem_ready), 32'd0);
    chk("rst_mid_data", read_data, 32'd0);
    mem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
    model_txn("r_200_after", 1, 0, 3'b010, 32'h200, 32'h0);

    // Upper address bits: rejected with the bounds check, aliased without it.
    model_txn("w_4", 0, 1, 3'b010, 32'h4, 32'h11223344);
    model_txn("w_hi", 0, 1, 3'b010, 32'h00020004, 32'h55667788);
    do_txn("r_hi", 1, 0, 3'b010, 32'h00020004, 32'h0, got);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("r_hi_data", got, 32'hDEADBEEF);
    last_rd = 32'hDEADBEEF;
`else
    chk("r_hi_data", got, 32'h55667788);
    last_rd = 32'h55667788;
`endif
    do_txn("r_4", 1, 0, 3'b010, 32'h4, 32'h0, got);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("r_4_data", got, 32'h11223344);
`else
    chk("r_4_data", got, 32'h55667788);
`endif
    last_rd = got;

    // Random traffic in a pre-initialised window.
    for (int a = 32'h1000; a < 32'h1040; a += 4)
      model_txn("init", 0, 1, 3'b010, 32'(a), $urandom);
    for (int k = 0; k < 80; k++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      int          op;
      sz = 3'($urandom_range(0, 7));
      a  = 32'h1000 + 32'($urandom_range(0, 60));
      op = $urandom_range(0, 5);
      if (op <= 2)      model_txn("rnd_rd", 1, 0, sz, a, 32'h0);
      else if (op <= 4) model_txn("rnd_wr", 0, 1, sz, a, $urandom);
      else              model_txn("rnd_both", 1, 1, sz, a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
